ngmux_sel_ctrl: RTL



---
 rtl/clk_mon_pkg.sv | 20 ++
 rtl/ngmux_sel_ctrl_if.sv | 14 +
 rtl/clk_edge_counter.sv | 77 +++++++
 rtl/ngmux_sel_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for clock-monitor based mux selection.
// Defaults assume a 40 MHz DCS clock measured against a 100 MHz reference.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_REF      = 2'd0,
        ST_HOLD_EXT = 2'd1,
        ST_EXT      = 2'd2,
        ST_HOLD_REF = 2'd3
    } sel_state_e;

    localparam int REF_CLK_HZ  = 100_000_000;
    localparam int DCS_CLK_HZ  = 40_000_000;
    localparam int DCS_WINDOW  = 1024;
    // Nominal edges per window: 1024 * 40 / 100 = 409.6
    localparam int DCS_CNT_NOM = DCS_WINDOW * (DCS_CLK_HZ / 1000) / (REF_CLK_HZ / 1000);
    localparam int DCS_CNT_MIN = 400;
    localparam int DCS_CNT_MAX = 420;

endpackage

// File: rtl/ngmux_sel_ctrl_if.sv
// Control/status bundle between firmware-side logic and the NGMUX select controller.
interface ngmux_sel_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             EN;
    logic             LOSS_CLR;
    logic             SEL;
    logic             EXT_ACTIVE;
    logic             LOSS_STICKY;
    logic [CNT_W-1:0] LAST_COUNT;

    modport master (output EN, LOSS_CLR, input SEL, EXT_ACTIVE, LOSS_STICKY, LAST_COUNT);
    modport slave  (input EN, LOSS_CLR, output SEL, EXT_ACTIVE, LOSS_STICKY, LAST_COUNT);
endinterface

// File: rtl/clk_edge_counter.sv
// Counts monitored-clock rising edges over a fixed reference-clock window and
// flags whether the completed window's count lies inside [CNT_MIN, CNT_MAX].
module clk_edge_counter
    import clk_mon_pkg::*;
#(
    parameter int WINDOW  = DCS_WINDOW,
    parameter int CNT_W   = 16,
    parameter int CNT_MIN = DCS_CNT_MIN,
    parameter int CNT_MAX = DCS_CNT_MAX
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mon_clk,
    output logic [CNT_W-1:0] o_last_count,
    output logic             o_win_end,
    output logic             o_good
);
    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(CNT_MAX);

    logic             r_tog;
    logic             r_sync_p0, r_sync_p1, r_sync_p2;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_last_count;
    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_SAT)) ? v + CNT_W'(1) : v;
    endfunction

    // Monitored-clock domain: one toggle per rising edge
    always_ff @(posedge i_mon_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tog <= 1'b0;
        else          r_tog <= ~r_tog;
    end

    // Reference domain: synchronise the toggle, one detected edge per change
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_sync_p2 <= 1'b0;
        end else begin
            r_sync_p0 <= r_tog;
            r_sync_p1 <= r_sync_p0;
            r_sync_p2 <= r_sync_p1;
        end
    end

    assign w_edge    = r_sync_p1 ^ r_sync_p2;
    assign w_cnt_now = sat_inc(r_edge_cnt, w_edge);
    assign o_win_end = (r_win_cnt == WIN_LAST);
    assign o_good    = (w_cnt_now >= MIN_C) && (w_cnt_now <= MAX_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_last_count <= '0;
        end else if (o_win_end) begin
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_last_count <= w_cnt_now;
        end else begin
            r_win_cnt    <= r_win_cnt + WIN_W'(1);
            r_edge_cnt   <= w_cnt_now;
        end
    end

    assign o_last_count = r_last_count;

endmodule

// File: rtl/ngmux_sel_ctrl.sv
// Drives NGMUX SEL: moves to the external clock after sustained good
// frequency windows and falls back to the local oscillator on loss or disable.
module ngmux_sel_ctrl
    import clk_mon_pkg::*;
#(
    parameter int WINDOW       = DCS_WINDOW,
    parameter int CNT_W        = 16,
    parameter int CNT_MIN      = DCS_CNT_MIN,
    parameter int CNT_MAX      = DCS_CNT_MAX,
    parameter int GOOD_WINDOWS = 4,
    parameter int BAD_WINDOWS  = 1,
    parameter int HOLDOFF      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CLK1_MON,
    ngmux_sel_ctrl_if.slave  ctrl
);
    localparam int              GW_W      = $clog2(GOOD_WINDOWS + 1);
    localparam int              BW_W      = $clog2(BAD_WINDOWS + 1);
    localparam int              HO_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [GW_W-1:0] GOOD_C    = GW_W'(GOOD_WINDOWS);
    localparam logic [BW_W-1:0] BAD_C     = BW_W'(BAD_WINDOWS);
    localparam logic [HO_W-1:0] HOLD_LAST = HO_W'(HOLDOFF - 1);

    sel_state_e       r_state, w_next;
    logic             r_sel;
    logic             r_loss;
    logic [HO_W-1:0]  r_hold;
    logic [GW_W-1:0]  r_good_cnt;
    logic [BW_W-1:0]  r_bad_cnt;
    logic [CNT_W-1:0] w_last_count;
    logic             w_win_end, w_win_good;
    logic             w_hold_done, w_in_hold;
    logic             w_enter_hold_ext, w_enter_hold_ref, w_loss_evt;

    function automatic logic [GW_W-1:0] sat_good(input logic [GW_W-1:0] v);
        return (v >= GOOD_C) ? GOOD_C : v + GW_W'(1);
    endfunction

    function automatic logic [BW_W-1:0] sat_bad(input logic [BW_W-1:0] v);
        return (v >= BAD_C) ? BAD_C : v + BW_W'(1);
    endfunction

    clk_edge_counter #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W),
        .CNT_MIN(CNT_MIN),
        .CNT_MAX(CNT_MAX)
    ) u_edge (
        .i_clk       (CLK),
        .i_rst_n     (RESET_N),
        .i_mon_clk   (CLK1_MON),
        .o_last_count(w_last_count),
        .o_win_end   (w_win_end),
        .o_good      (w_win_good)
    );

    assign w_hold_done      = (r_hold == HOLD_LAST);
    assign w_in_hold        = (r_state == ST_HOLD_EXT) || (r_state == ST_HOLD_REF);
    assign w_enter_hold_ext = (r_state != ST_HOLD_EXT) && (w_next == ST_HOLD_EXT);
    assign w_enter_hold_ref = (r_state != ST_HOLD_REF) && (w_next == ST_HOLD_REF);
    assign w_loss_evt       = (r_state == ST_EXT) && ctrl.EN && (r_bad_cnt >= BAD_C);

    // State register; SEL is registered from the next state so it never glitches
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_REF;
            r_sel   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= (w_next == ST_HOLD_EXT) || (w_next == ST_EXT);
            r_hold  <= (w_in_hold && (w_next == r_state)) ? r_hold + HO_W'(1) : '0;
        end
    end

    // Disable takes priority over every other decision and never marks a loss
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_REF:      if (ctrl.EN && (r_good_cnt >= GOOD_C)) w_next = ST_HOLD_EXT;
            ST_HOLD_EXT: if (!ctrl.EN)                           w_next = ST_HOLD_REF;
                         else if (w_hold_done)                   w_next = ST_EXT;
            ST_EXT:      if (!ctrl.EN || (r_bad_cnt >= BAD_C))   w_next = ST_HOLD_REF;
            ST_HOLD_REF: if (w_hold_done)                        w_next = ST_REF;
            default:                                             w_next = ST_REF;
        endcase
    end

    always_comb begin
        ctrl.SEL         = r_sel;
        ctrl.EXT_ACTIVE  = (r_state == ST_EXT);
        ctrl.LOSS_STICKY = r_loss;
        ctrl.LAST_COUNT  = w_last_count;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                         r_good_cnt <= '0;
        else if (!ctrl.EN || w_enter_hold_ref) r_good_cnt <= '0;
        else if (w_win_end)                   r_good_cnt <= w_win_good ? sat_good(r_good_cnt) : '0;
    end

    // Bad windows seen during HOLD_EXT are kept and judged on entry to EXT
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)              r_bad_cnt <= '0;
        else if (w_enter_hold_ext) r_bad_cnt <= '0;
        else if (w_win_end)        r_bad_cnt <= w_win_good ? '0 : sat_bad(r_bad_cnt);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)          r_loss <= 1'b0;
        else if (w_loss_evt)   r_loss <= 1'b1;
        else if (ctrl.LOSS_CLR) r_loss <= 1'b0;
    end

endmodule
